// File: rtl/synapse_current_if.sv
// ---------------------------------------------------------------------------
// synapse_current_if
//   Bundles the spike/config inputs and current outputs of synapse_current.
//
//   spikes_i     presynaptic spike vector, bit k = input k fired this cycle
//   en_i         1 = spikes accepted, 0 = spikes masked (leak continues)
//   cfg_we_i     weight write strobe
//   cfg_addr_i   weight index (3 bits)
//   cfg_wdata_i  weight write data
//   current_o    8-bit synaptic current to the neuron
//   sat_o        current_o is clamped at 255 this cycle
//
//   master: the spike source and configuration agent
//   slave : synapse_current itself
// ---------------------------------------------------------------------------
interface synapse_current_if #(
    parameter int N_IN    = 8,
    parameter int W_WIDTH = 4
);
    logic [N_IN-1:0]    spikes_i;
    logic               en_i;
    logic               cfg_we_i;
    logic [2:0]         cfg_addr_i;
    logic [W_WIDTH-1:0] cfg_wdata_i;
    logic [7:0]         current_o;
    logic               sat_o;

    modport master (
        output spikes_i, en_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
        input  current_o, sat_o
    );

    modport slave (
        input  spikes_i, en_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
        output current_o, sat_o
    );
endinterface

// File: rtl/synapse_current.sv
// ---------------------------------------------------------------------------
// synapse_current
//   Upstream stage of the LIF neuron: turns presynaptic spikes into a leaky,
//   saturating 8-bit current.
//
//   Pipeline (spike driven in cycle t):
//     edge t+1  spk_r   <= en ? spikes : 0
//     edge t+2  sum_r   <= sum of weights of inputs set in spk_r
//     edge t+3  current <= clamp255(current - leak + sum_r)
//
//   Ports:
//     clk_i   clock, all state on rising edge
//     rst_i   synchronous active-high reset (priority over everything)
//     bus     synapse_current_if.slave (spikes, enable, weight config,
//             current_o / sat_o)
// ---------------------------------------------------------------------------

// One weight register plus its gated contribution to the sum. One instance
// per input; an address that matches no instance is silently dropped, which
// is how writes beyond N_IN are ignored.
module synapse_lane #(
    parameter int W_WIDTH = 4,
    parameter int W_RESET = 1,
    parameter int LANE    = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_we_i,
    input  logic [2:0]         cfg_addr_i,
    input  logic [W_WIDTH-1:0] cfg_wdata_i,
    input  logic               spk_i,
    output logic [W_WIDTH-1:0] contrib_o
);
    localparam logic [2:0]         LANE_ADDR = 3'(LANE);
    localparam logic [W_WIDTH-1:0] W_INIT    = W_WIDTH'(W_RESET);

    logic [W_WIDTH-1:0] w_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            w_q <= W_INIT;
        else if (cfg_we_i && (cfg_addr_i == LANE_ADDR))
            w_q <= cfg_wdata_i;
    end

    // Reads the register, so a write in the same cycle as the spike is seen
    // here one edge later, when the spike has moved into spk_r.
    assign contrib_o = spk_i ? w_q : '0;
endmodule

module synapse_current #(
    parameter int N_IN        = 8,
    parameter int W_WIDTH     = 4,
    parameter int W_RESET     = 1,
    parameter int DECAY_SHIFT = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    synapse_current_if.slave bus
);
    // Sum width sized for all inputs firing at full weight: cannot overflow.
    localparam int SUM_W = $clog2(N_IN * ((1 << W_WIDTH) - 1) + 1);
    // At least 10 bits for cur - leak + sum; widen only for very wide sums.
    localparam int NXT_W = (SUM_W + 1 > 10) ? SUM_W + 1 : 10;

    // Stage 1: spike capture
    logic [N_IN-1:0] spk_r;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            spk_r <= '0;
        else
            spk_r <= bus.en_i ? bus.spikes_i : '0;
    end

    // Per-input weights and gated contributions
    logic [N_IN-1:0][W_WIDTH-1:0] contrib;

    genvar k;
    generate
        for (k = 0; k < N_IN; k++) begin : g_lane
            synapse_lane #(
                .W_WIDTH (W_WIDTH),
                .W_RESET (W_RESET),
                .LANE    (k)
            ) u_lane (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .cfg_we_i    (bus.cfg_we_i),
                .cfg_addr_i  (bus.cfg_addr_i),
                .cfg_wdata_i (bus.cfg_wdata_i),
                .spk_i       (spk_r[k]),
                .contrib_o   (contrib[k])
            );
        end
    endgenerate

    // Stage 2: weighted sum
    logic [SUM_W-1:0] sum_d;
    logic [SUM_W-1:0] sum_r;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N_IN; i++)
            sum_d = sum_d + SUM_W'(contrib[i]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            sum_r <= '0;
        else
            sum_r <= sum_d;
    end

    // Stage 3: leaky integration with saturation
    logic [7:0]       cur_q;
    logic             sat_q;
    logic [7:0]       shifted;
    logic [7:0]       leak;
    logic [NXT_W-1:0] nxt;
    logic             clamp;

    always_comb begin
        shifted = cur_q >> DECAY_SHIFT;
        // Floor of 1 keeps small values draining instead of sticking once
        // the shift rounds to zero. leak <= cur_q always, so no underflow.
        if (cur_q == 8'd0)
            leak = 8'd0;
        else if (shifted == 8'd0)
            leak = 8'd1;
        else
            leak = shifted;
        nxt   = NXT_W'(cur_q) - NXT_W'(leak) + NXT_W'(sum_r);
        clamp = (nxt > NXT_W'(255));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_q <= 8'd0;
            sat_q <= 1'b0;
        end else begin
            cur_q <= clamp ? 8'hFF : nxt[7:0];
            sat_q <= clamp;
        end
    end

    assign bus.current_o = cur_q;
    assign bus.sat_o     = sat_q;
endmodule

// File: tb/tb_synapse_current.sv
// ---------------------------------------------------------------------------
// tb_synapse_current
//   Directed, table-driven bench for synapse_current (N_IN=8, W_WIDTH=4,
//   W_RESET=1, DECAY_SHIFT=2). Each table row is the input set for one clock
//   edge plus the current_o/sat_o expected just after that edge. Drain and
//   mid-operation reset are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_synapse_current;
    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    synapse_current_if #(.N_IN(8), .W_WIDTH(4)) bus ();

    synapse_current #(
        .N_IN        (8),
        .W_WIDTH     (4),
        .W_RESET     (1),
        .DECAY_SHIFT (2)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] spk;
        logic       we;
        logic [2:0] addr;
        logic [3:0] wd;
        int         cur;
        logic       sat;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic add(input logic rst, input logic en, input logic [7:0] spk,
                       input logic we, input logic [2:0] addr, input logic [3:0] wd,
                       input int cur, input logic sat);
        vec_t v;
        v.rst = rst; v.en = en; v.spk = spk; v.we = we;
        v.addr = addr; v.wd = wd; v.cur = cur; v.sat = sat;
        tbl.push_back(v);
    endtask

    // idle row: enabled, no spikes, no write
    task automatic idle(input int cur, input logic sat);
        add(1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 4'd0, cur, sat);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [3:0] wd, input int cur);
        add(1'b0, 1'b1, 8'h00, 1'b1, addr, wd, cur, 1'b0);
    endtask

    task automatic drive(input logic rst, input logic en, input logic [7:0] spk,
                         input logic we, input logic [2:0] addr, input logic [3:0] wd);
        rst_i           = rst;
        bus.en_i        = en;
        bus.spikes_i    = spk;
        bus.cfg_we_i    = we;
        bus.cfg_addr_i  = addr;
        bus.cfg_wdata_i = wd;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input int idx, input int cur, input logic sat);
        n_chk++;
        if (bus.current_o === 8'(cur) && bus.sat_o === sat)
            n_pass++;
        else
            $display("FAIL %s[%0d]: current_o=%0d sat_o=%b, expected current_o=%0d sat_o=%b",
                     name, idx, bus.current_o, bus.sat_o, cur, sat);
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].spk, tbl[i].we, tbl[i].addr, tbl[i].wd);
            step();
            check(name, i, tbl[i].cur, tbl[i].sat);
        end
        tbl.delete();
    endtask

    // With the pipeline empty, current must fall strictly every cycle and
    // reach 0 within a bounded number of cycles, then stay there.
    task automatic drain(input string name);
        int  prev;
        bit  done;
        done = 1'b0;
        drive(1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 4'd0);
        for (int c = 0; c < 40 && !done; c++) begin
            prev = int'(bus.current_o);
            step();
            n_chk++;
            if (int'(bus.current_o) < prev && bus.sat_o === 1'b0) begin
                n_pass++;
            end else begin
                $display("FAIL %s[%0d]: current_o=%0d after %0d, expected strictly lower",
                         name, c, bus.current_o, prev);
                done = 1'b1;
            end
            if (bus.current_o == 8'd0) done = 1'b1;
        end
        step();
        check({name, "_zero"}, 0, 0, 1'b0);
    endtask

    initial begin
        drive(1'b1, 1'b1, 8'hFF, 1'b1, 3'd0, 4'd7);

        // Reset with spikes and a write pending: reset wins.
        add(1'b1, 1'b1, 8'hFF, 1'b1, 3'd0, 4'd7, 0, 1'b0);
        add(1'b1, 1'b1, 8'hFF, 1'b1, 3'd0, 4'd7, 0, 1'b0);
        // Every weight reads back 1: single-input spike shows 1 two rows on.
        for (int k = 0; k < 8; k++) begin
            add(1'b0, 1'b1, 8'(1 << k), 1'b0, 3'd0, 4'd0, 0, 1'b0);
            idle(0, 1'b0);
            idle(1, 1'b0);
            idle(0, 1'b0);
        end
        run_table("reset_weights");

        // Single spike with weight 4, then drain 4,3,2,1,0,0.
        for (int k = 0; k < 8; k++) wr(3'(k), 4'd4, 0);
        add(1'b0, 1'b1, 8'h01, 1'b0, 3'd0, 4'd0, 0, 1'b0);
        idle(0, 1'b0);
        idle(4, 1'b0);
        idle(3, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b0);
        idle(0, 1'b0);
        idle(0, 1'b0);
        run_table("single_spike");

        // Saturation: weights 15, all inputs for four cycles.
        for (int k = 0; k < 8; k++) wr(3'(k), 4'd15, 0);
        for (int i = 0; i < 4; i++)
            add(1'b0, 1'b1, 8'hFF, 1'b0, 3'd0, 4'd0, (i < 2) ? 0 : ((i == 2) ? 120 : 210), 1'b0);
        idle(255, 1'b1);
        idle(255, 1'b1);
        idle(192, 1'b0);
        idle(144, 1'b0);
        idle(108, 1'b0);
        run_table("saturation");
        drain("sat_drain");

        // Enable masking.
        for (int i = 0; i < 3; i++)
            add(1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 4'd0, 0, 1'b0);
        add(1'b0, 1'b1, 8'hFF, 1'b0, 3'd0, 4'd0, 0, 1'b0);
        idle(0, 1'b0);
        idle(120, 1'b0);
        idle(90, 1'b0);
        run_table("enable_mask");
        drain("en_drain");

        // Write/spike collision on input 2: new weight 9 is used, not 3.
        wr(3'd2, 4'd3, 0);
        add(1'b0, 1'b1, 8'h04, 1'b1, 3'd2, 4'd9, 0, 1'b0);
        idle(0, 1'b0);
        idle(9, 1'b0);
        idle(7, 1'b0);
        idle(6, 1'b0);
        idle(5, 1'b0);
        idle(4, 1'b0);
        idle(3, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b0);
        idle(0, 1'b0);
        // Zero weight contributes nothing, alone or alongside another input.
        wr(3'd3, 4'd0, 0);
        add(1'b0, 1'b1, 8'h08, 1'b0, 3'd0, 4'd0, 0, 1'b0);
        idle(0, 1'b0);
        idle(0, 1'b0);
        idle(0, 1'b0);
        add(1'b0, 1'b1, 8'h0C, 1'b0, 3'd0, 4'd0, 0, 1'b0);
        idle(0, 1'b0);
        idle(9, 1'b0);
        idle(7, 1'b0);
        run_table("collision");
        drain("col_drain");

        // Mid-operation reset with spikes in flight.
        wr(3'd2, 4'd15, 0);
        wr(3'd3, 4'd15, 0);
        run_table("restore");
        drive(1'b0, 1'b1, 8'hFF, 1'b0, 3'd0, 4'd0);
        for (int i = 0; i < 4; i++) step();
        check("mid_pre", 0, 210, 1'b0);
        drive(1'b1, 1'b1, 8'hFF, 1'b0, 3'd0, 4'd0);
        step();
        check("mid_rst", 0, 0, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_post", i, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
